nco_pwm_array: RTL

NCO_PWM_ARRAY -- requirements
Module: nco_pwm_array

---
 rtl/nco_pwm_array_if.sv | 27 ++
 rtl/nco_pwm_array.sv | 84 ++++++++
 2 files changed

// File: rtl/nco_pwm_array_if.sv
// Shadow-write / status bundle for nco_pwm_array. The controller drives the
// master side; the PWM array is the slave.
interface nco_pwm_array_if #(
    parameter int C_NCHAN     = 4,
    parameter int C_PWM_WIDTH = 24
);
    localparam int C_CHW = (C_NCHAN > 1) ? $clog2(C_NCHAN) : 1;

    logic [C_PWM_WIDTH-1:0] pwm_value_i;
    logic                   pwm_mode_i;
    logic [C_CHW-1:0]       pwm_chan_i;
    logic                   pwm_load_i;
    logic                   pwm_update_i;
    logic                   pwm_busy_o;
    logic                   frame_o;
    logic [C_NCHAN-1:0]     PWM;

    modport master (
        output pwm_value_i, pwm_mode_i, pwm_chan_i, pwm_load_i, pwm_update_i,
        input  pwm_busy_o, frame_o, PWM
    );

    modport slave (
        input  pwm_value_i, pwm_mode_i, pwm_chan_i, pwm_load_i, pwm_update_i,
        output pwm_busy_o, frame_o, PWM
    );
endinterface

// File: rtl/nco_pwm_array.sv
// Multi-channel PWM generator: each channel runs as an NCO (carry out of a
// phase accumulator) or an edge-aligned counter compare, with frame-synchronous commit.
module nco_pwm_array #(
    parameter int C_NCHAN     = 4,
    parameter int C_PWM_WIDTH = 24
) (
    input  logic            pwm_clk_i,
    input  logic            pwm_rst_i,
    nco_pwm_array_if.slave  bus
);
    localparam int W     = C_PWM_WIDTH;
    localparam int C_CHW = (C_NCHAN > 1) ? $clog2(C_NCHAN) : 1;
    localparam logic [W-1:0] F_MAX = '1;

    logic [W-1:0]       f_q, f_d;
    logic               pending_q, pending_d;
    logic [W-1:0]       sh_val_q  [C_NCHAN];
    logic [W-1:0]       sh_val_d  [C_NCHAN];
    logic               sh_mode_q [C_NCHAN];
    logic               sh_mode_d [C_NCHAN];
    logic [W-1:0]       act_val_q [C_NCHAN];
    logic [W-1:0]       act_val_d [C_NCHAN];
    logic               act_mode_q[C_NCHAN];
    logic               act_mode_d[C_NCHAN];
    logic [W-1:0]       acc_q     [C_NCHAN];
    logic [W-1:0]       acc_d     [C_NCHAN];
    logic [W:0]         sum       [C_NCHAN];
    logic [C_NCHAN-1:0] pwm_q, pwm_d;
    logic               commit;

    always_comb begin
        f_d       = f_q + 1'b1;
        // Commit only if the request was already pending entering the last cycle.
        commit    = (f_q == F_MAX) && pending_q;
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end else if (bus.pwm_update_i) begin
            pending_d = 1'b1;
        end
        pwm_d = '0;
        for (int c = 0; c < C_NCHAN; c++) begin
            sum[c]        = {1'b0, acc_q[c]} + {1'b0, act_val_q[c]};
            pwm_d[c]      = act_mode_q[c] ? (f_q < act_val_q[c]) : sum[c][W];
            acc_d[c]      = commit ? '0 : sum[c][W-1:0];
            act_val_d[c]  = commit ? sh_val_q[c]  : act_val_q[c];
            act_mode_d[c] = commit ? sh_mode_q[c] : act_mode_q[c];
            sh_val_d[c]   = sh_val_q[c];
            sh_mode_d[c]  = sh_mode_q[c];
            // Out-of-range indices match no channel and are dropped.
            if (bus.pwm_load_i && (bus.pwm_chan_i == C_CHW'(c))) begin
                sh_val_d[c]  = bus.pwm_value_i;
                sh_mode_d[c] = bus.pwm_mode_i;
            end
        end
    end

    always_ff @(posedge pwm_clk_i or posedge pwm_rst_i) begin
        if (pwm_rst_i) begin
            f_q        <= '0;
            pending_q  <= 1'b0;
            sh_val_q   <= '{default: '0};
            sh_mode_q  <= '{default: 1'b0};
            act_val_q  <= '{default: '0};
            act_mode_q <= '{default: 1'b0};
            acc_q      <= '{default: '0};
            pwm_q      <= '0;
        end else begin
            f_q        <= f_d;
            pending_q  <= pending_d;
            sh_val_q   <= sh_val_d;
            sh_mode_q  <= sh_mode_d;
            act_val_q  <= act_val_d;
            act_mode_q <= act_mode_d;
            acc_q      <= acc_d;
            pwm_q      <= pwm_d;
        end
    end

    assign bus.PWM        = pwm_q;
    assign bus.pwm_busy_o = pending_q;
    // Gated by reset so the frame marker stays low until counting resumes.
    assign bus.frame_o    = (f_q == '0) && !pwm_rst_i;
endmodule
